// File: rtl/product_accumulator.sv
// product_accumulator: sums a stream of signed 64-bit products into a wide
// accumulator, then emits one rounded, shifted and saturated 32-bit result
// per accumulation. Accumulations end on in_last or after MAX_LEN beats.
// The result is held under valid/ready backpressure; no product is accepted
// while a result is pending.
module product_accumulator #(
    parameter int SHIFT   = 16,
    parameter int MAX_LEN = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_product,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_sat,
    output logic        out_forced
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Half of one output LSB, added before the shift (round half up).
    // With SHIFT=0 there is nothing to round.
    localparam int          RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [72:0] RND     = (SHIFT > 0) ? (73'd1 << RND_POS) : 73'd0;

    // Signed 32-bit clamp bounds expressed in the 73-bit rounding domain.
    localparam logic signed [72:0] MAXV = 73'sd2147483647;
    localparam logic signed [72:0] MINV = -73'sd2147483648;

    localparam logic [8:0] LAST_CNT = 9'(MAX_LEN - 1);

    state_t             state_q, state_d;
    logic               live;       // low until the first edge after reset
    logic signed [71:0] acc;
    logic [8:0]         cnt;

    logic               accept;
    logic               at_max;
    logic               ending;
    logic signed [71:0] sum_total;
    logic signed [72:0] biased;
    logic signed [72:0] rounded;
    logic               sat_hi;
    logic               sat_lo;

    assign accept    = in_valid & in_ready;
    assign at_max    = (cnt == LAST_CNT);
    assign ending    = accept & (in_last | at_max);

    // The ending beat is folded in combinationally so the result can be
    // registered on the same edge the beat is accepted.
    assign sum_total = acc + {{8{in_product[63]}}, in_product};

    // One extra bit of headroom: a near-full-scale sum plus the rounding
    // constant would otherwise wrap.
    assign biased    = {sum_total[71], sum_total} + RND;
    assign rounded   = biased >>> SHIFT;
    assign sat_hi    = (rounded > MAXV);
    assign sat_lo    = (rounded < MINV);

    // State register; also tracks the first edge out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACC;
            live    <= 1'b0;
        end else begin
            state_q <= state_d;
            live    <= 1'b1;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACC: begin
                in_ready = live;
                if (in_valid && live && (in_last || at_max))
                    state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = ACC;
            end
            default: state_d = ACC;
        endcase
    end

    // Accumulator and beat counter; both restart on the ending beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (ending) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum_total;
                cnt <= cnt + 9'd1;
            end
        end
    end

    // Result registers: captured on the ending beat, held through HOLD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data   <= '0;
            out_sat    <= 1'b0;
            out_forced <= 1'b0;
        end else if (ending) begin
            if (sat_hi)
                out_data <= 32'h7FFF_FFFF;
            else if (sat_lo)
                out_data <= 32'h8000_0000;
            else
                out_data <= rounded[31:0];
            out_sat    <= sat_hi | sat_lo;
            out_forced <= at_max & ~in_last;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator (SHIFT=16, MAX_LEN=4).
// Directed scenarios plus randomized accumulations scored against a
// wide-integer arithmetic model of round/shift/clamp.
module tb_product_accumulator;

    localparam int SHIFT   = 16;
    localparam int MAX_LEN = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_product = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_sat;
    logic        out_forced;

    int total = 0;
    int bad   = 0;

    product_accumulator #(.SHIFT(SHIFT), .MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .out_forced (out_forced)
    );

    always #5 clk = ~clk;

    // Reference: round half up, shift, clamp to signed 32 bits. Returns {sat, data}.
    function automatic logic [32:0] model(input logic signed [80:0] s);
        logic signed [80:0] r;
        r = (s + (81'sd1 <<< (SHIFT - 1))) >>> SHIFT;
        if (r > 81'sd2147483647)       return {1'b1, 32'h7FFF_FFFF};
        else if (r < -81'sd2147483648) return {1'b1, 32'h8000_0000};
        else                           return {1'b0, r[31:0]};
    endfunction

    // Stimulus driver: waits (bounded) for in_ready, presents one beat for one edge.
    // Always entered and left just after a falling edge.
    task automatic beat(input logic [63:0] p, input logic last, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL beat_wait: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        @(negedge clk);
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_product = '0;
    endtask

    task automatic handshake(input int hold);
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        total++; if (out_sat !== 1'b0)   begin bad++; $display("FAIL rst_out_sat: got %0b want 0", out_sat); end
        total++; if (out_forced !== 1'b0) begin bad++; $display("FAIL rst_out_forced: got %0b want 0", out_forced); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_release_ready: got %0b want 0", in_ready); end
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_first_edge_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_sum_latency;
        beat(64'h30000, 1'b0, 0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sum_mid_valid: got %0b want 0", out_valid); end
        beat(64'h50000, 1'b1, 0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sum_latency: out_valid=%0b want 1", out_valid); end
        total++; if (out_data !== 32'd8) begin bad++; $display("FAIL sum_data: got %h want 8", out_data); end
        total++; if (out_sat !== 1'b0)   begin bad++; $display("FAIL sum_sat: got %0b want 0", out_sat); end
        total++; if (out_forced !== 1'b0) begin bad++; $display("FAIL sum_forced: got %0b want 0", out_forced); end
        handshake(0);
    endtask

    task automatic test_rounding;
        beat(64'h8000, 1'b1, 1);
        total++; if (out_data !== 32'd1) begin bad++; $display("FAIL round_pos_half: got %h want 1", out_data); end
        handshake(0);
        beat(-64'sh8000, 1'b1, 0);
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL round_neg_half: got %h want 0", out_data); end
        handshake(0);
        beat(-64'sh8001, 1'b1, 0);
        total++; if (out_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL round_neg_below: got %h want ffffffff", out_data); end
        handshake(0);
    endtask

    task automatic test_saturation;
        beat(64'h1 << 50, 1'b1, 0);
        total++; if (out_data !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_pos_data: got %h want 7fffffff", out_data); end
        total++; if (out_sat !== 1'b1) begin bad++; $display("FAIL sat_pos_flag: got %0b want 1", out_sat); end
        handshake(0);
        beat(-(64'sh1 <<< 50), 1'b1, 0);
        total++; if (out_data !== 32'h8000_0000) begin bad++; $display("FAIL sat_neg_data: got %h want 80000000", out_data); end
        total++; if (out_sat !== 1'b1) begin bad++; $display("FAIL sat_neg_flag: got %0b want 1", out_sat); end
        handshake(0);
        // Largest unclamped value: 0x7FFFFFFF << 16
        beat(64'h7FFF_FFFF_0000, 1'b1, 0);
        total++; if ({out_sat, out_data} !== {1'b0, 32'h7FFF_FFFF}) begin bad++; $display("FAIL sat_edge: got %0b/%h want 0/7fffffff", out_sat, out_data); end
        handshake(0);
    endtask

    task automatic test_backpressure;
        logic [31:0] held;
        beat(64'h00A0000, 1'b1, 0);
        held = out_data;
        total++; if (held !== 32'd10) begin bad++; $display("FAIL bp_data: got %h want a", held); end
        // Junk offered while holding must be ignored, including on the release edge.
        in_valid = 1'b1; in_product = 64'h7777_0000; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (out_data !== 32'd10 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d: data=%h valid=%0b ready=%0b want a/1/0", i, out_data, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_product = '0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: valid=%0b ready=%0b want 0/1", out_valid, in_ready); end
        beat(64'h10000, 1'b1, 0);
        total++; if (out_data !== 32'd1 || out_forced !== 1'b0) begin bad++; $display("FAIL bp_no_leak: data=%h forced=%0b want 1/0", out_data, out_forced); end
        handshake(0);
    endtask

    task automatic test_forced;
        for (int i = 0; i < 4; i++) beat(64'h10000, 1'b0, 0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL forced_valid: got %0b want 1", out_valid); end
        total++; if (out_data !== 32'd4) begin bad++; $display("FAIL forced_data: got %h want 4", out_data); end
        total++; if (out_forced !== 1'b1) begin bad++; $display("FAIL forced_flag: got %0b want 1", out_forced); end
        handshake(1);
        // in_last on the MAX_LEN-th beat is a normal end.
        for (int i = 0; i < 4; i++) beat(64'h10000, (i == 3), 0);
        total++; if (out_data !== 32'd4 || out_forced !== 1'b0) begin bad++; $display("FAIL last_at_max: data=%h forced=%0b want 4/0", out_data, out_forced); end
        handshake(0);
    endtask

    task automatic test_reset_mid;
        beat(64'h10000, 1'b0, 0);
        beat(64'h10000, 1'b0, 0);
        #2 reset = 1'b0;
        #1;
        total++; if ({in_ready, out_valid, out_data, out_sat, out_forced} !== 36'h0) begin
            bad++; $display("FAIL mid_reset_acc: ready=%0b valid=%0b data=%h sat=%0b forced=%0b want all 0", in_ready, out_valid, out_data, out_sat, out_forced);
        end
        @(negedge clk);
        reset = 1'b1;
        beat(64'h10000, 1'b1, 0);
        total++; if (out_data !== 32'd1 || out_forced !== 1'b0) begin bad++; $display("FAIL mid_reset_new: data=%h forced=%0b want 1/0", out_data, out_forced); end
        // Reset with a result pending drops it.
        #2 reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin bad++; $display("FAIL hold_reset: valid=%0b data=%h want 0/0", out_valid, out_data); end
        @(negedge clk);
        reset = 1'b1;
        beat(64'h30000, 1'b1, 0);
        total++; if (out_data !== 32'd3) begin bad++; $display("FAIL hold_reset_new: data=%h want 3", out_data); end
        handshake(0);
    endtask

    task automatic test_random;
        logic signed [80:0] sum;
        logic [63:0]        p;
        logic [32:0]        exp;
        longint             v;
        int                 len, n;
        logic               last, forced;
        for (int k = 0; k < 60; k++) begin
            len = $urandom_range(1, 6);
            sum = '0;
            n = (len < MAX_LEN) ? len : MAX_LEN;
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 2))
                    0: begin v = longint'($urandom_range(0, 2097152)) - 1048576; p = 64'(v); end
                    1: p = {$urandom, $urandom};
                    default: begin v = (longint'($urandom) - 64'sd2147483648) <<< 16; p = 64'(v); end
                endcase
                last = (i == len - 1);
                sum  = sum + {{17{p[63]}}, p};
                beat(p, last, $urandom_range(0, 2));
            end
            forced = (len > MAX_LEN);
            exp    = model(sum);
            total++; if (out_valid !== 1'b1 || out_data !== exp[31:0] || out_sat !== exp[32] || out_forced !== forced) begin
                bad++; $display("FAIL rand%0d: valid=%0b data=%h sat=%0b forced=%0b want 1/%h/%0b/%0b", k, out_valid, out_data, out_sat, out_forced, exp[31:0], exp[32], forced);
            end
            handshake($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset;
        test_sum_latency;
        test_rounding;
        test_saturation;
        test_backpressure;
        test_forced;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
